// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller.
// Contents:
//   TIME_W             - width of hour/minute values
//   HR_MAX_DEF/MIN_MAX_DEF - default wrap limits
//   state_t            - controller state encoding (also the mode output)
//   wrap_inc/wrap_dec  - modular +1/-1 over 0..max
package clock_pkg;
  localparam int TIME_W      = 6;
  localparam int HR_MAX_DEF  = 23;
  localparam int MIN_MAX_DEF = 59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v == max) ? '0 : v + TIME_ONE;
  endfunction

  function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v == '0) ? max : v - TIME_ONE;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_btn_step_gen.sv
// Edge detect plus auto-repeat for one debounced button.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn       - debounced, synchronised button level
//   en        - allows steps and auto-repeat; 0 gives edge detection only
//   clr       - clears the hold counter (state change / conflicting button)
//   press     - rising edge of btn (combinational from registered history)
//   step      - press while enabled, or an auto-repeat pulse
// A repeat sequence is only armed by a real press, so a button already held
// when the history was reset (history resets to 1) never steps.
module btn_step_gen #(
  parameter int HOLD_CYC = 50000000,
  parameter int REP_CYC  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic en,
  input  logic clr,
  output logic press,
  output logic step
);
  localparam int CNT_W = $clog2(((HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC) + 1);

  logic             r_prev;
  logic             r_armed;
  logic             r_rep;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;
  logic             w_rpt;

  // r_cnt holds cycles elapsed since the last step; first gap is HOLD_CYC,
  // later gaps are REP_CYC.
  assign w_target = r_rep ? CNT_W'(REP_CYC) : CNT_W'(HOLD_CYC);
  assign w_rpt    = r_armed & btn & en & ~clr & (r_cnt == w_target);
  assign press    = btn & ~r_prev;
  assign step     = (press & en) | w_rpt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
      r_rep   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_prev <= btn;
      if (!btn || !en) begin
        r_armed <= 1'b0;
        r_rep   <= 1'b0;
        r_cnt   <= '0;
      end else if (press) begin
        r_armed <= 1'b1;
        r_rep   <= 1'b0;
        r_cnt   <= CNT_W'(1);
      end else if (clr) begin
        r_armed <= 1'b0;
        r_rep   <= 1'b0;
        r_cnt   <= '0;
      end else if (r_armed) begin
        if (w_rpt) begin
          r_rep <= 1'b1;
          r_cnt <= CNT_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and time-setting controller for the digital clock.
// Walks RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN on mode presses, edits the
// captured time with inc/dec (with auto-repeat), pauses the counter chain
// while editing and strobes load for one cycle on commit. An edit is
// abandoned (no load) after TIMEOUT_S idle seconds.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   tick_1hz                  - 1 Hz single-cycle enable
//   btn_mode/btn_inc/btn_dec  - debounced button levels
//   cur_hr/cur_min            - live time, captured on entering edit
//   run_en                    - counter chain count enable
//   load, load_hr, load_min   - load strobe and value
//   edit_hr, edit_min         - value under edit
//   mode                      - current state encoding
//   blink                     - blink phase of the edited field
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HR_MAX    = HR_MAX_DEF,
  parameter int MIN_MAX   = MIN_MAX_DEF,
  parameter int HOLD_CYC  = 50000000,
  parameter int REP_CYC   = 10000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [TIME_W-1:0] cur_hr,
  input  logic [TIME_W-1:0] cur_min,
  output logic              run_en,
  output logic              load,
  output logic [TIME_W-1:0] load_hr,
  output logic [TIME_W-1:0] load_min,
  output logic [TIME_W-1:0] edit_hr,
  output logic [TIME_W-1:0] edit_min,
  output logic [1:0]        mode,
  output logic              blink
);
  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [TIME_W-1:0] HR_LIM  = TIME_W'(HR_MAX);
  localparam logic [TIME_W-1:0] MIN_LIM = TIME_W'(MIN_MAX);

  state_t            r_state;
  state_t            r_state_d;
  logic              r_run_en;
  logic              r_load;
  logic [TIME_W-1:0] r_load_hr;
  logic [TIME_W-1:0] r_load_min;
  logic [TIME_W-1:0] r_edit_hr;
  logic [TIME_W-1:0] r_edit_min;
  logic              r_blink;
  logic [IDLE_W-1:0] r_idle;

  logic w_in_set;
  logic w_state_chg;
  logic w_mode_press, w_mode_step;
  logic w_inc_press, w_inc_step;
  logic w_dec_press, w_dec_step;
  logic w_inc_ok, w_dec_ok;
  logic w_activity;
  logic w_timeout;

  assign w_in_set    = (r_state == SET_HR) || (r_state == SET_MIN);
  // One-cycle-late view of a state change; restarts any hold in progress.
  assign w_state_chg = (r_state != r_state_d);

  btn_step_gen #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .en(1'b0), .clr(1'b0),
    .press(w_mode_press), .step(w_mode_step)
  );
  btn_step_gen #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .en(w_in_set),
    .clr(btn_dec | w_state_chg), .press(w_inc_press), .step(w_inc_step)
  );
  btn_step_gen #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dec (
    .clk(clk), .rst(rst), .btn(btn_dec), .en(w_in_set),
    .clr(btn_inc | w_state_chg), .press(w_dec_press), .step(w_dec_step)
  );

  // A step is discarded whenever the opposite button is also down.
  assign w_inc_ok   = w_inc_step & ~btn_dec;
  assign w_dec_ok   = w_dec_step & ~btn_inc;
  assign w_activity = w_mode_press | w_mode_step | w_inc_press | w_dec_press |
                      w_inc_step | w_dec_step;
  assign w_timeout  = tick_1hz & ~w_activity & (r_idle == IDLE_W'(TIMEOUT_S - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_state_d  <= RUN;
      r_run_en   <= 1'b1;
      r_load     <= 1'b0;
      r_load_hr  <= '0;
      r_load_min <= '0;
      r_edit_hr  <= '0;
      r_edit_min <= '0;
      r_blink    <= 1'b0;
      r_idle     <= '0;
    end else begin
      r_state_d <= r_state;
      case (r_state)
        RUN: begin
          r_run_en <= 1'b1;
          r_load   <= 1'b0;
          r_blink  <= 1'b0;
          r_idle   <= '0;
          if (w_mode_press) begin
            r_state    <= SET_HR;
            r_run_en   <= 1'b0;
            r_edit_hr  <= (cur_hr > HR_LIM) ? '0 : cur_hr;
            r_edit_min <= (cur_min > MIN_LIM) ? '0 : cur_min;
          end
        end
        SET_HR, SET_MIN: begin
          if (w_mode_press) begin
            r_blink <= 1'b0;
            r_idle  <= '0;
            if (r_state == SET_HR) begin
              r_state <= SET_MIN;
            end else begin
              r_state    <= COMMIT;
              r_load     <= 1'b1;
              r_load_hr  <= r_edit_hr;
              r_load_min <= r_edit_min;
            end
          end else if (w_timeout) begin
            r_state  <= RUN;
            r_run_en <= 1'b1;
            r_blink  <= 1'b0;
            r_idle   <= '0;
          end else begin
            if (r_state == SET_HR) begin
              if (w_inc_ok)      r_edit_hr <= wrap_inc(r_edit_hr, HR_LIM);
              else if (w_dec_ok) r_edit_hr <= wrap_dec(r_edit_hr, HR_LIM);
            end else begin
              if (w_inc_ok)      r_edit_min <= wrap_inc(r_edit_min, MIN_LIM);
              else if (w_dec_ok) r_edit_min <= wrap_dec(r_edit_min, MIN_LIM);
            end
            if (tick_1hz) r_blink <= ~r_blink;
            if (w_activity)    r_idle <= '0;
            else if (tick_1hz) r_idle <= r_idle + IDLE_W'(1);
          end
        end
        COMMIT: begin
          r_load   <= 1'b0;
          r_run_en <= 1'b1;
          r_blink  <= 1'b0;
          r_state  <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign run_en   = r_run_en;
  assign load     = r_load;
  assign load_hr  = r_load_hr;
  assign load_min = r_load_min;
  assign edit_hr  = r_edit_hr;
  assign edit_min = r_edit_min;
  assign mode     = r_state;
  assign blink    = r_blink;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with short hold/repeat/timeout values.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [5:0] cur_hr = '0;
  logic [5:0] cur_min = '0;
  logic       run_en, load, blink;
  logic [5:0] load_hr, load_min, edit_hr, edit_min;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;

  clock_set_ctrl #(
    .HR_MAX(23), .MIN_MAX(59), .HOLD_CYC(10), .REP_CYC(4), .TIMEOUT_S(3)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hr(cur_hr), .cur_min(cur_min),
    .run_en(run_en), .load(load), .load_hr(load_hr), .load_min(load_min),
    .edit_hr(edit_hr), .edit_min(edit_min), .mode(mode), .blink(blink)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (load) load_cnt++;

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cyc(1); btn_inc = 1'b0; cyc(1);
  endtask

  task automatic press_dec();
    btn_dec = 1'b1; cyc(1); btn_dec = 1'b0; cyc(1);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (run_en !== 1'b1) begin failures++; $display("FAIL reset_run_en got=%0b exp=1", run_en); end
    checks++; if (load !== 1'b0 || blink !== 1'b0) begin failures++; $display("FAIL reset_load_blink got=%0b%0b exp=00", load, blink); end
    checks++; if ({load_hr, load_min, edit_hr, edit_min} !== 24'd0) begin failures++; $display("FAIL reset_values got=%0d/%0d/%0d/%0d exp=0", load_hr, load_min, edit_hr, edit_min); end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_enter();
    do_reset();
    cur_hr = 6'd14; cur_min = 6'd37;
    press_mode();
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL enter_mode got=%0d exp=1", mode); end
    checks++; if (edit_hr !== 6'd14 || edit_min !== 6'd37) begin failures++; $display("FAIL enter_capture got=%0d:%0d exp=14:37", edit_hr, edit_min); end
    checks++; if (run_en !== 1'b0) begin failures++; $display("FAIL enter_run_en got=%0b exp=0", run_en); end
  endtask

  task automatic test_wrap_commit();
    do_reset();
    cur_hr = 6'd23; cur_min = 6'd0;
    press_mode();
    press_inc();
    checks++; if (edit_hr !== 6'd0) begin failures++; $display("FAIL hr_inc_wrap got=%0d exp=0", edit_hr); end
    press_dec();
    checks++; if (edit_hr !== 6'd23) begin failures++; $display("FAIL hr_dec_wrap got=%0d exp=23", edit_hr); end
    press_mode();
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL to_set_min got=%0d exp=2", mode); end
    press_dec();
    checks++; if (edit_min !== 6'd59) begin failures++; $display("FAIL min_dec_wrap got=%0d exp=59", edit_min); end
    load_cnt = 0;
    btn_mode = 1'b1; cyc(1);
    checks++; if (mode !== 2'd3 || load !== 1'b1) begin failures++; $display("FAIL commit_cycle got mode=%0d load=%0b exp mode=3 load=1", mode, load); end
    checks++; if (load_hr !== 6'd23 || load_min !== 6'd59) begin failures++; $display("FAIL commit_value got=%0d:%0d exp=23:59", load_hr, load_min); end
    btn_mode = 1'b0; cyc(1);
    checks++; if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0) begin failures++; $display("FAIL after_commit got mode=%0d run_en=%0b load=%0b exp 0/1/0", mode, run_en, load); end
    cyc(3);
    checks++; if (load_cnt !== 1) begin failures++; $display("FAIL load_pulses got=%0d exp=1", load_cnt); end
    checks++; if (load_hr !== 6'd23 || load_min !== 6'd59) begin failures++; $display("FAIL load_hold got=%0d:%0d exp=23:59", load_hr, load_min); end
  endtask

  task automatic test_repeat();
    do_reset();
    cur_hr = 6'd0; cur_min = 6'd5;
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    cyc(10);
    checks++; if (edit_min !== 6'd6) begin failures++; $display("FAIL rpt_before_hold got=%0d exp=6", edit_min); end
    cyc(1);
    checks++; if (edit_min !== 6'd7) begin failures++; $display("FAIL rpt_first got=%0d exp=7", edit_min); end
    cyc(19);
    btn_inc = 1'b0;
    cyc(2);
    checks++; if (edit_min !== 6'd11) begin failures++; $display("FAIL rpt_total got=%0d exp=11", edit_min); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cur_hr = 6'd7; cur_min = 6'd20;
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
    checks++; if (mode !== 2'd2 || edit_hr !== 6'd7) begin failures++; $display("FAIL mode_wins got mode=%0d hr=%0d exp mode=2 hr=7", mode, edit_hr); end
    btn_inc = 1'b1; btn_dec = 1'b1; cyc(15);
    btn_inc = 1'b0; btn_dec = 1'b0; cyc(2);
    checks++; if (edit_min !== 6'd20 || mode !== 2'd2) begin failures++; $display("FAIL inc_dec_both got min=%0d mode=%0d exp min=20 mode=2", edit_min, mode); end
  endtask

  task automatic test_timeout();
    do_reset();
    cur_hr = 6'd3; cur_min = 6'd4;
    load_cnt = 0;
    press_mode();
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL blink_enter got=%0b exp=0", blink); end
    pulse_tick();
    checks++; if (blink !== 1'b1 || mode !== 2'd1) begin failures++; $display("FAIL blink_toggle got blink=%0b mode=%0d exp 1/1", blink, mode); end
    pulse_tick();
    checks++; if (blink !== 1'b0 || mode !== 2'd1) begin failures++; $display("FAIL blink_toggle2 got blink=%0b mode=%0d exp 0/1", blink, mode); end
    pulse_tick();
    checks++; if (mode !== 2'd0 || run_en !== 1'b1 || blink !== 1'b0) begin failures++; $display("FAIL timeout got mode=%0d run_en=%0b blink=%0b exp 0/1/0", mode, run_en, blink); end
    checks++; if (load_cnt !== 0) begin failures++; $display("FAIL timeout_no_load got=%0d exp=0", load_cnt); end
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    cur_hr = 6'd9; cur_min = 6'd30;
    load_cnt = 0;
    press_mode();
    press_mode();
    press_inc();
    rst = 1'b1; btn_inc = 1'b1; cyc(1);
    checks++; if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0) begin failures++; $display("FAIL reset_mid got mode=%0d run_en=%0b load=%0b exp 0/1/0", mode, run_en, load); end
    checks++; if (edit_min !== 6'd0 || load_cnt !== 0) begin failures++; $display("FAIL reset_discard got min=%0d loads=%0d exp 0/0", edit_min, load_cnt); end
    rst = 1'b0; cyc(2);
    press_mode();
    cyc(15);
    checks++; if (edit_hr !== 6'd9 || mode !== 2'd1) begin failures++; $display("FAIL held_inc_no_step got hr=%0d mode=%0d exp 9/1", edit_hr, mode); end
    btn_inc = 1'b0; cyc(1);
  endtask

  initial begin
    test_reset();
    test_enter();
    test_wrap_commit();
    test_repeat();
    test_simultaneous();
    test_timeout();
    test_reset_mid_edit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode and time-setting controller for the digital clock. It sequences the user through hour edit and minute edit from three buttons, then loads the result into the time_hr/time_min counter chain. While editing, it pauses timekeeping. It sits between the debounced button inputs and the counter datapath, and drives the display-select and blink outputs.

Parameters:
HR_MAX, 23, largest hour value; hours wrap HR_MAX<->0
MIN_MAX, 59, largest minute value; minutes wrap MIN_MAX<->0
HOLD_CYC, 50000000, clk cycles a button must be held before the first auto-repeat step
REP_CYC, 10000000, clk cycles between subsequent auto-repeat steps
TIMEOUT_S, 30, tick_1hz pulses without activity before an edit is abandoned

Ports:
clk  in  1  clock
rst  in  1  reset
tick_1hz  in  1  single-cycle 1 Hz enable pulse from the seconds stage
btn_mode  in  1  debounced, synchronised level
btn_inc  in  1  debounced, synchronised level
btn_dec  in  1  debounced, synchronised level
cur_hr  in  6  live hour count
cur_min  in  6  live minute count
run_en  out  1  counter chain count enable
load  out  1  single-cycle load strobe to counters; counters also clear seconds
load_hr  out  6  hour value to load
load_min  out  6  minute value to load
edit_hr  out  6  hour value being edited, for display
edit_min  out  6  minute value being edited, for display
mode  out  2  current state encoding
blink  out  1  display blink phase for the field being edited

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. On reset: state RUN, run_en=1, load=0, load_hr/load_min/edit_hr/edit_min=0, blink=0, all counters 0.
- Button-history registers reset to 1. A button held through reset therefore produces no press.
- A press is the rising edge of a button level, detected one cycle after the level rises.
- States are RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3. Outputs are registered; mode reflects the state.
- RUN: run_en=1. A mode press moves to SET_HR and captures edit_hr<=cur_hr and edit_min<=cur_min. A captured value above its MAX is replaced by 0. run_en=0 from the cycle the state becomes SET_HR.
- SET_HR:
  - An inc step sets edit_hr = (edit_hr==HR_MAX) ? 0 : edit_hr+1.
  - A dec step sets edit_hr = (edit_hr==0) ? HR_MAX : edit_hr-1.
  - A mode press moves to SET_MIN.
- SET_MIN: same inc/dec rules applied to edit_min with MIN_MAX. A mode press moves to COMMIT.
- COMMIT lasts exactly one cycle: load=1, load_hr=edit_hr, load_min=edit_min, then RUN. run_en=1 from the cycle after COMMIT. load_hr/load_min hold their value afterwards.
- Step generation:
  - A step is a press, or an auto-repeat while exactly one of inc/dec stays high in a SET state.
  - The first repeat fires HOLD_CYC cycles after the press; later repeats fire every REP_CYC cycles.
  - The hold counter clears on release, on a state change, or when both buttons are high.
- Simultaneous events:
  - inc and dec in the same cycle: both are ignored.
  - mode with inc or dec in the same cycle: mode wins and the step is discarded.
- Timeout: the idle counter counts tick_1hz pulses in SET_HR/SET_MIN and clears on any press or step. When it reaches TIMEOUT_S, the block returns to RUN with no load pulse, and run_en=1 on the next cycle.
- blink: set to 0 on entering SET_HR or SET_MIN, toggles on each tick_1hz while in a SET state, and is forced to 0 in RUN and COMMIT.
- Reset mid-edit: returns to RUN, with no load and the edits discarded.
- Arithmetic is 6-bit unsigned with no overflow beyond MAX by construction. The hold and idle counters use $clog2-sized widths.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum (RUN, SET_HR, SET_MIN, COMMIT)
  - TIME_W=6
  - default HR_MAX/MIN_MAX
- One sub-module is natural: btn_step_gen, which does edge detection plus auto-repeat for a single button. It takes parameters HOLD_CYC and REP_CYC and an enable input, and outputs press and step. It is instantiated for inc and dec; btn_mode uses its edge output only, with enable=0.

Test Plan:
- Reset, then mode press with cur_hr=14, cur_min=37 -> mode=1, edit_hr=14, edit_min=37, run_en=0 on the next cycle.
- SET_HR at edit_hr=23: inc -> 0; dec -> 23. SET_MIN at edit_min=0: dec -> 59. Three mode presses from RUN -> exactly one load cycle with the edited values, then mode=0 and run_en=1.
- HOLD_CYC=10, REP_CYC=4: hold inc for 30 cycles in SET_MIN from 5 -> steps at press, +10, +14, +18, +22, +26; edit_min=11.
- mode and inc in the same cycle in SET_HR at edit_hr=7 -> state SET_MIN, edit_hr stays 7. inc and dec together -> no change.
- TIMEOUT_S=3: enter SET_HR, send 3 tick_1hz pulses with no buttons -> mode=0, load never asserted, blink=0, run_en=1.
- rst asserted during SET_MIN -> the next cycle mode=0, run_en=1, load=0. btn_inc held across reset release -> no step.
